// File: rtl/frame_stats.sv
// Per-frame statistics: sum of squares and peak |sample| over DEPTH samples,
// presented on a valid/ready result port. Optional macro: FRAME_STATS_RESTART_EN.
module frame_stats #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned DEPTH        = 256,
  parameter int unsigned ADDR_WIDTH   = $clog2(DEPTH),
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned ACC_WIDTH    = 2 * SAMPLE_WIDTH + ADDR_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    frame_start_i,
  input  logic [WIDTH-1:0]        sample_data_i,
  input  logic                    sample_valid_i,
  output logic                    sample_ready_o,
  output logic [ACC_WIDTH-1:0]    energy_o,
  output logic [SAMPLE_WIDTH-1:0] peak_o,
  output logic                    result_valid_o,
  input  logic                    result_ready_i,
  output logic                    busy_o,
  output logic                    frame_error_o,
  output logic [ADDR_WIDTH:0]     sample_count_o
);

  localparam int unsigned CNT_W  = ADDR_WIDTH + 1;
  localparam int unsigned PROD_W = 2 * SAMPLE_WIDTH;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;

  state_e                  state_q;
  logic [ACC_WIDTH-1:0]    acc_q, acc_d;
  logic [SAMPLE_WIDTH-1:0] pk_q, pk_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ACC_WIDTH-1:0]    energy_q;
  logic [SAMPLE_WIDTH-1:0] peak_q;
  logic                    ready_q, valid_q, busy_q, err_q;

  logic signed [SAMPLE_WIDTH-1:0] smp;
  logic signed [PROD_W-1:0]       smp_w, sq;
  logic [SAMPLE_WIDTH-1:0]        mag;
  logic                           accept;
  logic                           unused_upper;

  assign unused_upper = ^sample_data_i;

  // Datapath: square, magnitude and the would-be updated running values
  always_comb begin
    smp    = $signed(sample_data_i[SAMPLE_WIDTH-1:0]);
    smp_w  = PROD_W'(smp);
    sq     = smp_w * smp_w;
    mag    = smp[SAMPLE_WIDTH-1] ? $unsigned(-smp) : $unsigned(smp);
    acc_d  = acc_q + ACC_WIDTH'($unsigned(sq));
    pk_d   = (mag > pk_q) ? mag : pk_q;
    cnt_d  = cnt_q + CNT_W'(1);
    accept = sample_valid_i && ready_q;
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      pk_q     <= '0;
      cnt_q    <= '0;
      energy_q <= '0;
      peak_q   <= '0;
      ready_q  <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (frame_start_i) begin
            acc_q   <= '0;
            pk_q    <= '0;
            cnt_q   <= '0;
            state_q <= ACCUM;
            ready_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        ACCUM: begin
          if (frame_start_i) begin
            err_q <= 1'b1;
          end
`ifdef FRAME_STATS_RESTART_EN
          if (frame_start_i) begin
            // A restart discards any sample offered in the same cycle
            acc_q <= '0;
            pk_q  <= '0;
            cnt_q <= '0;
          end else if (accept) begin
`else
          if (accept) begin
`endif
            acc_q <= acc_d;
            pk_q  <= pk_d;
            cnt_q <= cnt_d;
            if (cnt_d == CNT_LAST) begin
              energy_q <= acc_d;
              peak_q   <= pk_d;
              state_q  <= DONE;
              ready_q  <= 1'b0;
              valid_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          if (result_ready_i) begin
            valid_q <= 1'b0;
            if (frame_start_i) begin
              acc_q   <= '0;
              pk_q    <= '0;
              cnt_q   <= '0;
              state_q <= ACCUM;
              ready_q <= 1'b1;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else if (frame_start_i) begin
            err_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign sample_ready_o = ready_q;
  assign energy_o       = energy_q;
  assign peak_o         = peak_q;
  assign result_valid_o = valid_q;
  assign busy_o         = busy_q;
  assign frame_error_o  = err_q;
  assign sample_count_o = cnt_q;

endmodule

// File: tb/tb_frame_stats.sv
// Directed self-checking bench for frame_stats with DEPTH=4, SAMPLE_WIDTH=16.
module tb_frame_stats;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;
  localparam int unsigned SW    = 16;
  localparam int unsigned ACCW  = 2 * SW + AW;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            frame_start_i;
  logic [WIDTH-1:0] sample_data_i;
  logic            sample_valid_i;
  logic            sample_ready_o;
  logic [ACCW-1:0] energy_o;
  logic [SW-1:0]   peak_o;
  logic            result_valid_o;
  logic            result_ready_i;
  logic            busy_o;
  logic            frame_error_o;
  logic [AW:0]     sample_count_o;

  int n_tests = 0;
  int n_fail  = 0;

  frame_stats #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .SAMPLE_WIDTH(SW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .frame_start_i(frame_start_i),
    .sample_data_i(sample_data_i), .sample_valid_i(sample_valid_i),
    .sample_ready_o(sample_ready_o), .energy_o(energy_o), .peak_o(peak_o),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .busy_o(busy_o), .frame_error_o(frame_error_o),
    .sample_count_o(sample_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Upper bits carry junk so that the sample field extraction is exercised
  task automatic drive_sample(input logic signed [SW-1:0] s);
    sample_valid_i = 1'b1;
    sample_data_i  = {16'hA5C3, s};
  endtask

  task automatic start_frame();
    frame_start_i = 1'b1;
    tick();
    frame_start_i = 1'b0;
  endtask

  task automatic feed(input logic signed [SW-1:0] s);
    drive_sample(s);
    tick();
  endtask

  task automatic take_result();
    sample_valid_i = 1'b0;
    result_ready_i = 1'b1;
    tick();
    result_ready_i = 1'b0;
    check_eq("rvalid_after_take", 64'(result_valid_o), 64'd0);
  endtask

  logic [ACCW-1:0] exp_e;
  int              guard;

  initial begin
    rst_ni = 1'b0; frame_start_i = 1'b0; sample_data_i = '0;
    sample_valid_i = 1'b0; result_ready_i = 1'b0;
    #1;
    check_eq("rst_energy", 64'(energy_o), 64'd0);
    check_eq("rst_peak",   64'(peak_o), 64'd0);
    check_eq("rst_rvalid", 64'(result_valid_o), 64'd0);
    check_eq("rst_ready",  64'(sample_ready_o), 64'd0);
    check_eq("rst_busy",   64'(busy_o), 64'd0);
    check_eq("rst_count",  64'(sample_count_o), 64'd0);
    #11 rst_ni = 1'b1;

    // valid while idle is ignored and raises no error
    sample_valid_i = 1'b1;
    tick(); tick();
    check_eq("idle_count", 64'(sample_count_o), 64'd0);
    check_eq("idle_err",   64'(frame_error_o), 64'd0);
    sample_valid_i = 1'b0;

    // Frame 1: 1,-2,3,-4 -> 30, peak 4
    start_frame();
    check_eq("f1_ready", 64'(sample_ready_o), 64'd1);
    check_eq("f1_busy",  64'(busy_o), 64'd1);
    feed(16'sd1); feed(-16'sd2); feed(16'sd3);
    check_eq("f1_count3", 64'(sample_count_o), 64'd3);
    check_eq("f1_rvalid_early", 64'(result_valid_o), 64'd0);
    feed(-16'sd4);
    check_eq("f1_rvalid", 64'(result_valid_o), 64'd1);
    check_eq("f1_energy", 64'(energy_o), 64'd30);
    check_eq("f1_peak",   64'(peak_o), 64'd4);

    // Back-pressure: hold result for 10 cycles with valid high
    for (int i = 0; i < 10; i++) begin
      feed(16'sd7);
      check_eq("hold_rvalid", 64'(result_valid_o), 64'd1);
      check_eq("hold_energy", 64'(energy_o), 64'd30);
      check_eq("hold_ready",  64'(sample_ready_o), 64'd0);
      check_eq("hold_count",  64'(sample_count_o), 64'(DEPTH));
    end
    take_result();
    check_eq("f1_busy_idle", 64'(busy_o), 64'd0);
    check_eq("f1_energy_kept", 64'(energy_o), 64'd30);

    // Frame 2: four times -32768
    start_frame();
    for (int i = 0; i < 4; i++) feed(-16'sd32768);
    check_eq("f2_energy", 64'(energy_o), 64'h1_0000_0000);
    check_eq("f2_peak",   64'(peak_o), 64'h8000);

    // start in DONE without accept: error, result untouched
    sample_valid_i = 1'b0;
    frame_start_i  = 1'b1;
    tick();
    frame_start_i  = 1'b0;
    check_eq("done_start_err", 64'(frame_error_o), 64'd1);
    check_eq("done_start_rvalid", 64'(result_valid_o), 64'd1);
    tick();
    check_eq("err_pulse_len", 64'(frame_error_o), 64'd0);
    take_result();

    // Frame 3: start in the middle of ACCUM
    start_frame();
    feed(16'sd1); feed(16'sd1);
    sample_valid_i = 1'b0;
    frame_start_i  = 1'b1;
    tick();
    frame_start_i  = 1'b0;
    check_eq("mid_start_err", 64'(frame_error_o), 64'd1);
`ifdef FRAME_STATS_RESTART_EN
    exp_e = ACCW'(16);
`else
    exp_e = ACCW'(10);
`endif
    guard = 0;
    while (!result_valid_o && guard < 8) begin
      feed(16'sd2);
      guard++;
    end
    sample_valid_i = 1'b0;
    check_eq("mid_done", 64'(result_valid_o), 64'd1);
    check_eq("mid_energy", 64'(energy_o), 64'(exp_e));
    check_eq("mid_peak", 64'(peak_o), 64'd2);

    // Result accept and start in the same cycle
    result_ready_i = 1'b1;
    frame_start_i  = 1'b1;
    tick();
    result_ready_i = 1'b0;
    frame_start_i  = 1'b0;
    check_eq("bb_err",    64'(frame_error_o), 64'd0);
    check_eq("bb_ready",  64'(sample_ready_o), 64'd1);
    check_eq("bb_rvalid", 64'(result_valid_o), 64'd0);
    check_eq("bb_count",  64'(sample_count_o), 64'd0);

    // Asynchronous reset in the middle of ACCUM
    feed(16'sd5); feed(16'sd5);
    sample_valid_i = 1'b0;
    #1 rst_ni = 1'b0;
    #1;
    check_eq("ar_ready",  64'(sample_ready_o), 64'd0);
    check_eq("ar_busy",   64'(busy_o), 64'd0);
    check_eq("ar_count",  64'(sample_count_o), 64'd0);
    check_eq("ar_energy", 64'(energy_o), 64'd0);
    check_eq("ar_peak",   64'(peak_o), 64'd0);
    check_eq("ar_rvalid", 64'(result_valid_o), 64'd0);
    #2 rst_ni = 1'b1;
    tick();
    check_eq("ar_idle_ready", 64'(sample_ready_o), 64'd0);
    check_eq("ar_idle_busy",  64'(busy_o), 64'd0);

    // Clean frame after reset: 3,0,-1,2 -> 14, peak 3
    start_frame();
    feed(16'sd3); feed(16'sd0); feed(-16'sd1); feed(16'sd2);
    sample_valid_i = 1'b0;
    check_eq("f4_energy", 64'(energy_o), 64'd14);
    check_eq("f4_peak",   64'(peak_o), 64'd3);
    take_result();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
